// File: rtl/pwm_fade_multi.sv
// pwm_fade_multi: N-channel PWM fade engine, one shared PWM counter and fade-phase accumulator, per-channel phase offsets.
// Latency: PWM_OUT/PWM_CLK_OUT/PERIOD_START registered one clock after the counter; no backpressure (free-running).
// Define PWM_FADE_GAMMA_EN for square-law level mapping (adds one register stage ahead of the period latch).
module pwm_fade_multi #(
   parameter int CHANNELS   = 2,
   parameter int PWM_WIDTH  = 16,
   parameter int FADE_WIDTH = 9,
   parameter int STEP_DIV   = 131072
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic [1:0]            MODE,
   input  logic [FADE_WIDTH-1:0] LEVEL,
   output logic [CHANNELS-1:0]   PWM_OUT,
   output logic                  PWM_CLK_OUT,
   output logic                  PERIOD_START
);
   localparam int PH_W  = FADE_WIDTH + 1;
   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   generate
      if (FADE_WIDTH > PWM_WIDTH || FADE_WIDTH < 1) begin : g_bad_fade_width
         $error("pwm_fade_multi: FADE_WIDTH must be in 1..PWM_WIDTH");
      end
      if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
         $error("pwm_fade_multi: CHANNELS must be in 1..16");
      end
      if (STEP_DIV < 2) begin : g_bad_step_div
         $error("pwm_fade_multi: STEP_DIV must be >= 2");
      end
`ifdef PWM_FADE_GAMMA_EN
      if (2 * FADE_WIDTH < PWM_WIDTH) begin : g_bad_gamma_width
         $error("pwm_fade_multi: gamma mapping needs 2*FADE_WIDTH >= PWM_WIDTH");
      end
`endif
   endgenerate

   logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [PH_W-1:0]      phase_q, phase_d;
   logic [CHANNELS-1:0]  pwm_q, pwm_d;
   logic                 pwm_clk_q, pwm_clk_d;
   logic                 period_start_q, period_start_d;
   logic                 tick;
   logic                 period_end;
   logic [CHANNELS-1:0][PWM_WIDTH-1:0] cmp_act;

   assign tick       = (div_q == DIV_W'(STEP_DIV - 1));
   assign period_end = &cnt_q;

   always_comb begin
      cnt_d          = cnt_q + PWM_WIDTH'(1);
      div_d          = tick ? '0 : div_q + DIV_W'(1);
      phase_d        = (tick && EN) ? phase_q + PH_W'(1) : phase_q;
      pwm_clk_d      = cnt_q[PWM_WIDTH-1];
      period_start_d = (cnt_q == '0);
      pwm_d          = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         pwm_d[i] = (cnt_q < cmp_act[i]);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q          <= '0;
         div_q          <= '0;
         phase_q        <= '0;
         pwm_q          <= '0;
         pwm_clk_q      <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         div_q          <= div_d;
         phase_q        <= phase_d;
         pwm_q          <= pwm_d;
         pwm_clk_q      <= pwm_clk_d;
         period_start_q <= period_start_d;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      // Offsets spread the channels evenly around one full fade cycle.
      localparam logic [PH_W-1:0] OFF = PH_W'((i * (2 ** PH_W)) / CHANNELS);

      logic [PH_W-1:0]       p;
      logic [FADE_WIDTH-1:0] lv;
      logic [PWM_WIDTH-1:0]  cmp_nxt;
      logic [PWM_WIDTH-1:0]  cmp_act_q, cmp_act_d;

      always_comb begin
         p  = phase_q + OFF;
         lv = '0;
         case (MODE)
            2'd0:    lv = p[FADE_WIDTH] ? ~p[FADE_WIDTH-1:0] : p[FADE_WIDTH-1:0];
            2'd1:    lv = p[FADE_WIDTH-1:0];
            2'd2:    lv = LEVEL;
            default: lv = '0;
         endcase
      end

`ifdef PWM_FADE_GAMMA_EN
      logic [PWM_WIDTH-1:0] sq_q, sq_d;

      // Keep only the top PWM_WIDTH bits of the square; the period latch reads the registered copy.
      always_comb begin
         sq_d = PWM_WIDTH'(({{FADE_WIDTH{1'b0}}, lv} * {{FADE_WIDTH{1'b0}}, lv})
                           >> (2 * FADE_WIDTH - PWM_WIDTH));
      end

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            sq_q <= '0;
         end else begin
            sq_q <= sq_d;
         end
      end

      assign cmp_nxt = sq_q;
`else
      assign cmp_nxt = PWM_WIDTH'(lv) << (PWM_WIDTH - FADE_WIDTH);
`endif

      always_comb begin
         cmp_act_d = period_end ? cmp_nxt : cmp_act_q;
      end

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            cmp_act_q <= '0;
         end else begin
            cmp_act_q <= cmp_act_d;
         end
      end

      assign cmp_act[i] = cmp_act_q;
   end

   assign PWM_OUT      = pwm_q;
   assign PWM_CLK_OUT  = pwm_clk_q;
   assign PERIOD_START = period_start_q;

endmodule

// File: tb/tb_pwm_fade_multi.sv
// Bench for pwm_fade_multi at PWM_WIDTH=4, FADE_WIDTH=3, STEP_DIV=4, CHANNELS=2 (16-clock period, ch1 offset 8).
// Expected per-period compare values are queued as stimulus is driven and checked against captured 16-cycle waveforms.
module tb_pwm_fade_multi;
   localparam int PW = 4;
   localparam int FW = 3;
   localparam int CH = 2;
   localparam int SD = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          EN;
   logic [1:0]    MODE;
   logic [FW-1:0] LEVEL;
   logic [CH-1:0] PWM_OUT;
   logic          PWM_CLK_OUT;
   logic          PERIOD_START;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      string name;
      int    c0;
      int    c1;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [1:0]    mode;
      logic [FW-1:0] level;
      int            cmp;
   } vec_t;
   vec_t tbl[9];

   pwm_fade_multi #(
      .CHANNELS  (CH),
      .PWM_WIDTH (PW),
      .FADE_WIDTH(FW),
      .STEP_DIV  (SD)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .EN          (EN),
      .MODE        (MODE),
      .LEVEL       (LEVEL),
      .PWM_OUT     (PWM_OUT),
      .PWM_CLK_OUT (PWM_CLK_OUT),
      .PERIOD_START(PERIOD_START)
   );

   always #5 CLK = ~CLK;

   function automatic int cmp_of(input int lv);
`ifdef PWM_FADE_GAMMA_EN
      return (lv * lv) >> (2 * FW - PW);
`else
      return lv << (PW - FW);
`endif
   endfunction

   // Triangle: rising 0..7 in the lower half of the phase circle, falling 7..0 in the upper half.
   function automatic int lv_breathe(input int p);
      int q;
      q = p % 16;
      return (q >= 8) ? (7 - (q % 8)) : q;
   endfunction

   function automatic int mask_of(input int cmp);
      return (1 << cmp) - 1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input string name, input int c0, input int c1);
      exp_t e;
      e.name = name;
      e.c0   = c0;
      e.c1   = c1;
      sb.push_back(e);
   endtask

   task automatic wait_ps();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge CLK);
         if (PERIOD_START) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL period_start_timeout: no pulse in 64 cycles, expected one every 16");
      end
   endtask

   // Captures one period starting at the PERIOD_START sample; optionally switches MODE after sample chg_at.
   task automatic check_period(input int chg_at, input logic [1:0] chg_mode);
      int   m0, m1, mc;
      exp_t e;
      wait_ps();
      m0 = 0;
      m1 = 0;
      mc = 0;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge CLK);
         m0 |= int'(PWM_OUT[0]) << k;
         m1 |= int'(PWM_OUT[1]) << k;
         mc |= int'(PWM_CLK_OUT) << k;
         if (k == chg_at) MODE = chg_mode;
      end
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard_empty: period captured with no expectation queued");
      end else begin
         e = sb.pop_front();
         check({e.name, "_ch0"}, m0, mask_of(e.c0));
         check({e.name, "_ch1"}, m1, mask_of(e.c1));
         check({e.name, "_clk"}, mc, 16'hFF00);
      end
   endtask

   initial begin
      tbl[0] = '{2'd1, 3'd0, 0};
      tbl[1] = '{2'd2, 3'd5, 0};
      tbl[2] = '{2'd2, 3'd0, 0};
      tbl[3] = '{2'd2, 3'd7, 0};
      tbl[4] = '{2'd2, 3'd2, 0};
      tbl[5] = '{2'd2, 3'd3, 0};
      tbl[6] = '{2'd2, 3'd6, 0};
      tbl[7] = '{2'd3, 3'd7, 0};
      tbl[8] = '{2'd2, 3'd4, 0};
`ifdef PWM_FADE_GAMMA_EN
      tbl[0].cmp = 4;  tbl[1].cmp = 6;  tbl[2].cmp = 0;
      tbl[3].cmp = 12; tbl[4].cmp = 1;  tbl[5].cmp = 2;
      tbl[6].cmp = 9;  tbl[7].cmp = 0;  tbl[8].cmp = 4;
`else
      tbl[0].cmp = 8;  tbl[1].cmp = 10; tbl[2].cmp = 0;
      tbl[3].cmp = 14; tbl[4].cmp = 4;  tbl[5].cmp = 6;
      tbl[6].cmp = 12; tbl[7].cmp = 0;  tbl[8].cmp = 8;
`endif

      RST   = 1'b1;
      EN    = 1'b1;
      MODE  = 2'd0;
      LEVEL = '0;
      repeat (3) @(negedge CLK);
      check("reset_pwm_out", int'(PWM_OUT), 0);
      check("reset_pwm_clk", int'(PWM_CLK_OUT), 0);
      check("reset_period_start", int'(PERIOD_START), 0);

      // Breathe from reset: period j latches the phase reached 4*j-1 steps in.
      RST = 1'b0;
      push("breathe_p0", 0, 0);
      check_period(-1, 2'd0);
      for (int j = 1; j <= 8; j++) begin
         push($sformatf("breathe_p%0d", j),
              cmp_of(lv_breathe(4 * j - 1)), cmp_of(lv_breathe(4 * j - 1 + 8)));
         check_period(-1, 2'd0);
      end

      // Freeze: the in-flight period still carries phase 3; the phase then sits at 4.
      EN = 1'b0;
      push("freeze_inflight", cmp_of(lv_breathe(3)), cmp_of(lv_breathe(11)));
      check_period(-1, 2'd0);
      for (int k = 0; k < 3; k++) begin
         push($sformatf("freeze_%0d", k), cmp_of(lv_breathe(4)), cmp_of(lv_breathe(12)));
         check_period(-1, 2'd0);
      end
      EN = 1'b1;
      push("resume_held", cmp_of(lv_breathe(4)), cmp_of(lv_breathe(12)));
      check_period(-1, 2'd0);
      push("resume_step1", cmp_of(lv_breathe(7)), cmp_of(lv_breathe(15)));
      check_period(-1, 2'd0);
      // Freeze again so the table below sees a known phase of 12.
      EN = 1'b0;
      push("resume_step2", cmp_of(lv_breathe(11)), cmp_of(lv_breathe(19)));
      check_period(-1, 2'd0);

      for (int i = 0; i < 9; i++) begin
         MODE  = tbl[i].mode;
         LEVEL = tbl[i].level;
         push($sformatf("table_v%0d", i), tbl[i].cmp, tbl[i].cmp);
         wait_ps();
         check_period(-1, 2'd0);
      end

      // Mode change mid-period must not disturb the running period.
      MODE  = 2'd2;
      LEVEL = 3'd7;
      push("glitch_current", cmp_of(7), cmp_of(7));
      wait_ps();
      check_period(2, 2'd3);
      push("glitch_next", 0, 0);
      check_period(-1, 2'd0);

      // Reset mid-run, right at a period start while both outputs are high.
      MODE = 2'd2;
      wait_ps();
      wait_ps();
      check("pre_reset_pwm_out", int'(PWM_OUT), 3);
      check("pre_reset_period_start", int'(PERIOD_START), 1);
      RST = 1'b1;
      #1;
      check("mid_reset_pwm_out", int'(PWM_OUT), 0);
      check("mid_reset_period_start", int'(PERIOD_START), 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      push("post_reset_first", 0, 0);
      check_period(-1, 2'd0);
      push("post_reset_second", cmp_of(7), cmp_of(7));
      check_period(-1, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 time units");
      $fatal(1, "watchdog");
   end

endmodule
